// File: rtl/addr_decoder_reg_pkg.sv
// Shared types and coding constants for the registered address decoder.
// Imported by the decode sub-module and the top.
package addr_dec_pkg;

    typedef enum logic {
        IDLE   = 1'b0,
        ACTIVE = 1'b1
    } state_t;

    localparam int CODE_ONEHOT = 0;
    localparam int CODE_THERMO = 1;
    localparam int MODE_PULSE  = 0;
    localparam int MODE_LEVEL  = 1;

endpackage

// File: rtl/addr_decoder_reg_if.sv
// Request/select bus between one requesting master and the decoder.
// The master issues addresses; the decoder returns strobes and status.
interface addr_decoder_reg_if #(
    parameter int ADDR_W  = 3,
    parameter int NUM_OUT = 8
);
    logic              req_valid;
    logic              req_ready;
    logic [ADDR_W-1:0] req_addr;
    logic [NUM_OUT-1:0] sel;
    logic              sel_valid;
    logic              sel_ack;
    logic              err;
    logic              err_clr;
    logic              busy;

    modport master (
        output req_valid, req_addr, sel_ack, err_clr,
        input  req_ready, sel, sel_valid, err, busy
    );

    modport slave (
        input  req_valid, req_addr, sel_ack, err_clr,
        output req_ready, sel, sel_valid, err, busy
    );
endinterface

// File: rtl/addr_decoder_reg_decode.sv
// Combinational address decode: one-hot or thermometer select plus range flag.
// Out-of-range addresses still yield known values; the top gates them.
module addr_decode_comb
    import addr_dec_pkg::*;
#(
    parameter int ADDR_W   = 3,
    parameter int NUM_OUT  = 8,
    parameter int OUT_CODE = CODE_ONEHOT
) (
    input  logic [ADDR_W-1:0]  addr_i,
    output logic [NUM_OUT-1:0] sel_o,
    output logic               in_range_o
);
    logic [31:0] addr_w;

    assign addr_w     = 32'(addr_i);
    assign in_range_o = (addr_w < 32'(NUM_OUT));

    for (genvar i = 0; i < NUM_OUT; i++) begin : g_sel
        localparam logic [31:0] IDX = 32'(i);
        if (OUT_CODE == CODE_THERMO) begin : g_thermo
            assign sel_o[i] = (IDX <= addr_w);
        end else begin : g_onehot
            assign sel_o[i] = (IDX == addr_w);
        end
    end
endmodule

// File: rtl/addr_decoder_reg.sv
// Registered address decoder with request/ack handshake, pulse or level
// strobes and a sticky out-of-range error flag.
module addr_decoder_reg
    import addr_dec_pkg::*;
#(
    parameter int ADDR_W    = 3,
    parameter int NUM_OUT   = 8,
    parameter int OUT_CODE  = CODE_ONEHOT,
    parameter int MODE      = MODE_PULSE,
    parameter int PULSE_LEN = 1
) (
    input  logic               clk,
    input  logic               rst_n,
    addr_decoder_reg_if.slave  bus
);
    localparam int CNT_W = $clog2(PULSE_LEN + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(PULSE_LEN - 1);

    state_t             state_q;
    logic [NUM_OUT-1:0] sel_q;
    logic               sel_valid_q;
    logic               busy_q;
    logic               ready_q;
    logic [CNT_W-1:0]   cnt_q;
    logic               err_q;
    logic               err_d;

    logic [NUM_OUT-1:0] dec_sel;
    logic               in_range;
    logic               accept;
    logic               done;

    addr_decode_comb #(
        .ADDR_W   (ADDR_W),
        .NUM_OUT  (NUM_OUT),
        .OUT_CODE (OUT_CODE)
    ) u_dec (
        .addr_i     (bus.req_addr),
        .sel_o      (dec_sel),
        .in_range_o (in_range)
    );

    // Handshake, strobe completion and sticky error next state (set beats clear).
    always_comb begin
        accept = bus.req_valid & ready_q;
        done   = 1'b0;
        if (MODE == MODE_LEVEL) begin
            done = bus.sel_ack;
        end else begin
            done = (cnt_q == CNT_LAST);
        end
        err_d = err_q;
        if (accept && !in_range) begin
            err_d = 1'b1;
        end else if (bus.err_clr) begin
            err_d = 1'b0;
        end
    end

    // Two-state FSM with all outputs held in flops.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            sel_q       <= '0;
            sel_valid_q <= 1'b0;
            busy_q      <= 1'b0;
            ready_q     <= 1'b1;
            cnt_q       <= '0;
            err_q       <= 1'b0;
        end else begin
            err_q <= err_d;
            unique case (state_q)
                IDLE: begin
                    if (accept && in_range) begin
                        state_q     <= ACTIVE;
                        sel_q       <= dec_sel;
                        sel_valid_q <= 1'b1;
                        busy_q      <= 1'b1;
                        ready_q     <= 1'b0;
                        cnt_q       <= '0;
                    end
                end
                ACTIVE: begin
                    if (done) begin
                        state_q     <= IDLE;
                        sel_q       <= '0;
                        sel_valid_q <= 1'b0;
                        busy_q      <= 1'b0;
                        ready_q     <= 1'b1;
                        cnt_q       <= '0;
                    end else if (MODE == MODE_PULSE) begin
                        cnt_q <= cnt_q + CNT_W'(1);
                    end
                end
                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end

    assign bus.req_ready = ready_q;
    assign bus.sel       = sel_q;
    assign bus.sel_valid = sel_valid_q;
    assign bus.busy      = busy_q;
    assign bus.err       = err_q;
endmodule

// File: tb/tb_addr_decoder_reg.sv
// Scoreboard bench for addr_decoder_reg over five parameter sets.
// Expected strobes are queued at drive time and matched by a monitor.
module tb_addr_decoder_reg;

    typedef struct {
        logic [15:0] sel;
        int          len;
        int          start;
    } exp_t;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   cyc = 0;
    int   n_chk = 0;
    int   n_fail = 0;
    int   dsel = 0;
    exp_t sb[$];

    addr_decoder_reg_if #(.ADDR_W(3), .NUM_OUT(8))  if0 ();
    addr_decoder_reg_if #(.ADDR_W(4), .NUM_OUT(12)) if1 ();
    addr_decoder_reg_if #(.ADDR_W(3), .NUM_OUT(6))  if2 ();
    addr_decoder_reg_if #(.ADDR_W(3), .NUM_OUT(8))  if3 ();
    addr_decoder_reg_if #(.ADDR_W(3), .NUM_OUT(8))  if4 ();

    addr_decoder_reg #(.ADDR_W(3), .NUM_OUT(8), .OUT_CODE(0),
        .MODE(0), .PULSE_LEN(1))
        u0 (.clk(clk), .rst_n(rst_n), .bus(if0));
    addr_decoder_reg #(.ADDR_W(4), .NUM_OUT(12), .OUT_CODE(1),
        .MODE(0), .PULSE_LEN(1))
        u1 (.clk(clk), .rst_n(rst_n), .bus(if1));
    addr_decoder_reg #(.ADDR_W(3), .NUM_OUT(6), .OUT_CODE(0),
        .MODE(0), .PULSE_LEN(1))
        u2 (.clk(clk), .rst_n(rst_n), .bus(if2));
    addr_decoder_reg #(.ADDR_W(3), .NUM_OUT(8), .OUT_CODE(0),
        .MODE(1), .PULSE_LEN(1))
        u3 (.clk(clk), .rst_n(rst_n), .bus(if3));
    addr_decoder_reg #(.ADDR_W(3), .NUM_OUT(8), .OUT_CODE(0),
        .MODE(0), .PULSE_LEN(3))
        u4 (.clk(clk), .rst_n(rst_n), .bus(if4));

    initial forever #5 clk = ~clk;
    initial forever begin
        @(posedge clk);
        cyc++;
    end

    logic [15:0] obs_sel;
    logic obs_sv, obs_rdy, obs_busy;

    always_comb begin
        obs_sel  = '0;
        obs_sv   = 1'b0;
        obs_rdy  = 1'b0;
        obs_busy = 1'b0;
        case (dsel)
            0: begin obs_sel = 16'(if0.sel); obs_sv = if0.sel_valid;
                     obs_rdy = if0.req_ready; obs_busy = if0.busy; end
            1: begin obs_sel = 16'(if1.sel); obs_sv = if1.sel_valid;
                     obs_rdy = if1.req_ready; obs_busy = if1.busy; end
            2: begin obs_sel = 16'(if2.sel); obs_sv = if2.sel_valid;
                     obs_rdy = if2.req_ready; obs_busy = if2.busy; end
            3: begin obs_sel = 16'(if3.sel); obs_sv = if3.sel_valid;
                     obs_rdy = if3.req_ready; obs_busy = if3.busy; end
            default: begin obs_sel = 16'(if4.sel); obs_sv = if4.sel_valid;
                     obs_rdy = if4.req_ready; obs_busy = if4.busy; end
        endcase
    end

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
        end
    endtask

    task automatic drv(input int d, input logic v, input int a,
                       input logic ack, input logic clr);
        case (d)
            0: begin if0.req_valid = v; if0.req_addr = 3'(a);
                     if0.sel_ack = ack; if0.err_clr = clr; end
            1: begin if1.req_valid = v; if1.req_addr = 4'(a);
                     if1.sel_ack = ack; if1.err_clr = clr; end
            2: begin if2.req_valid = v; if2.req_addr = 3'(a);
                     if2.sel_ack = ack; if2.err_clr = clr; end
            3: begin if3.req_valid = v; if3.req_addr = 3'(a);
                     if3.sel_ack = ack; if3.err_clr = clr; end
            default: begin if4.req_valid = v; if4.req_addr = 3'(a);
                     if4.sel_ack = ack; if4.err_clr = clr; end
        endcase
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // One single-cycle request; expected strobe queued before the accept edge.
    task automatic req1(input int d, input int a, input logic [15:0] s,
                        input int len);
        exp_t e;
        e.sel = s;
        e.len = len;
        e.start = cyc + 1;
        sb.push_back(e);
        drv(d, 1'b1, a, 1'b0, 1'b0);
        tick();
        drv(d, 1'b0, 0, 1'b0, 1'b0);
    endtask

    // Strobe monitor on the falling edge for the selected DUT.
    initial begin
        bit   on = 1'b0;
        int   len = 0;
        int   elen = 0;
        logic [15:0] hsel = '0;
        exp_t e;
        forever begin
            @(negedge clk);
            if (rst_n) begin
                chk("ready_vs_valid", 32'(obs_rdy), 32'(!obs_sv));
                chk("busy_vs_valid", 32'(obs_busy), 32'(obs_sv));
                if (!obs_sv) chk("sel_zero", 32'(obs_sel), 32'h0);
                if (obs_sv && !on) begin
                    on = 1'b1;
                    len = 1;
                    if (sb.size() == 0) begin
                        chk("unexpected_strobe", 32'h1, 32'h0);
                        elen = 0;
                        hsel = obs_sel;
                    end else begin
                        e = sb.pop_front();
                        chk("sel", 32'(obs_sel), 32'(e.sel));
                        chk("start_cyc", 32'(cyc), 32'(e.start));
                        elen = e.len;
                        hsel = e.sel;
                    end
                end else if (obs_sv) begin
                    len++;
                    chk("sel_hold", 32'(obs_sel), 32'(hsel));
                end else if (on) begin
                    chk("strobe_len", 32'(len), 32'(elen));
                    on = 1'b0;
                end
            end else begin
                on = 1'b0;
            end
        end
    end

    initial begin
        exp_t e;
        for (int d = 0; d < 5; d++) drv(d, 1'b0, 0, 1'b0, 1'b0);
        repeat (2) @(posedge clk);
        #1;
        chk("rst_sel", 32'(if0.sel), 32'h0);
        chk("rst_sv", 32'(if0.sel_valid), 32'h0);
        chk("rst_err", 32'(if0.err), 32'h0);
        chk("rst_busy", 32'(if0.busy), 32'h0);
        chk("rst_ready", 32'(if0.req_ready), 32'h1);
        chk("rst_ready4", 32'(if4.req_ready), 32'h1);
        rst_n = 1'b1;
        tick();

        // Reset asserted in the middle of an active strobe
        dsel = 0;
        drv(0, 1'b1, 5, 1'b0, 1'b0);
        tick();
        drv(0, 1'b0, 0, 1'b0, 1'b0);
        chk("t1_active", 32'(if0.sel_valid), 32'h1);
        chk("t1_sel", 32'(if0.sel), 32'h20);
        #2 rst_n = 1'b0;
        #1;
        chk("t1_rst_sel", 32'(if0.sel), 32'h0);
        chk("t1_rst_sv", 32'(if0.sel_valid), 32'h0);
        chk("t1_rst_err", 32'(if0.err), 32'h0);
        chk("t1_rst_busy", 32'(if0.busy), 32'h0);
        #1 rst_n = 1'b1;
        tick();
        chk("t1_ready", 32'(if0.req_ready), 32'h1);
        tick();

        // One-hot sweep, one-cycle pulses
        for (int a = 0; a < 8; a++) begin
            req1(0, a, 16'(1) << a, 1);
            chk("t2_ready_low", 32'(if0.req_ready), 32'h0);
            tick();
        end
        tick();
        chk("t2_sb_empty", 32'(sb.size()), 32'h0);

        // Thermometer coding, 12 outputs
        dsel = 1;
        tick();
        req1(1, 0, 16'h0001, 1);
        tick();
        req1(1, 5, 16'h003F, 1);
        tick();
        req1(1, 11, 16'h0FFF, 1);
        tick();
        drv(1, 1'b1, 13, 1'b0, 1'b0);
        tick();
        drv(1, 1'b0, 0, 1'b0, 1'b0);
        chk("t3_err", 32'(if1.err), 32'h1);
        tick();
        chk("t3_sb_empty", 32'(sb.size()), 32'h0);

        // Out-of-range error and clear priority
        dsel = 2;
        tick();
        drv(2, 1'b1, 6, 1'b0, 1'b0);
        tick();
        chk("t4_err_set", 32'(if2.err), 32'h1);
        chk("t4_no_strobe", 32'(if2.sel_valid), 32'h0);
        chk("t4_ready", 32'(if2.req_ready), 32'h1);
        drv(2, 1'b1, 7, 1'b0, 1'b1);
        tick();
        chk("t4_set_wins", 32'(if2.err), 32'h1);
        drv(2, 1'b0, 0, 1'b0, 1'b1);
        tick();
        chk("t4_err_clr", 32'(if2.err), 32'h0);
        drv(2, 1'b0, 0, 1'b0, 1'b0);
        req1(2, 5, 16'h0020, 1);
        tick();
        chk("t4_err_stays0", 32'(if2.err), 32'h0);
        tick();

        // Level mode held by sel_ack
        dsel = 3;
        tick();
        req1(3, 3, 16'h0008, 5);
        repeat (3) tick();
        chk("t5_held", 32'(if3.sel_valid), 32'h1);
        tick();
        drv(3, 1'b0, 0, 1'b1, 1'b0);
        tick();
        chk("t5_released", 32'(if3.sel_valid), 32'h0);
        drv(3, 1'b0, 0, 1'b0, 1'b0);
        tick();
        e.sel = 16'h0002;
        e.len = 1;
        e.start = cyc + 1;
        sb.push_back(e);
        drv(3, 1'b1, 1, 1'b1, 1'b0);
        tick();
        drv(3, 1'b0, 0, 1'b1, 1'b0);
        tick();
        drv(3, 1'b0, 0, 1'b0, 1'b0);
        tick();
        chk("t5_sb_empty", 32'(sb.size()), 32'h0);

        // Back-to-back 3-cycle pulses with req_valid held high
        dsel = 4;
        tick();
        e.sel = 16'h0004;
        e.len = 3;
        e.start = cyc + 1;
        sb.push_back(e);
        e.sel = 16'h0010;
        e.start = cyc + 5;
        sb.push_back(e);
        drv(4, 1'b1, 2, 1'b0, 1'b0);
        tick();
        drv(4, 1'b1, 4, 1'b0, 1'b0);
        repeat (4) tick();
        drv(4, 1'b0, 0, 1'b0, 1'b0);
        repeat (4) tick();
        chk("t6_sb_empty", 32'(sb.size()), 32'h0);
        chk("t6_idle", 32'(if4.busy), 32'h0);

        $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
        $finish;
    end

endmodule
